// File: rtl/act_lut_scheduler_pkg.sv
// Shared constants, FSM state encoding and data type for the activation LUT scheduler
// and the interpolator it drives.
package act_lut_scheduler_pkg;

  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int ADDR_W = DATA_W - FRAC_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    CALC   = 2'd2,
    ACK    = 2'd3
  } state_e;

  typedef logic signed [DATA_W-1:0] data_t;

endpackage

// File: rtl/act_lut_scheduler_if.sv
// Requester and LUT-side signals of the scheduler. The scheduler uses the slave view;
// the neuron/LUT environment uses the master view.
interface act_lut_scheduler_if #(parameter int NUM_REQ = 4);
  import act_lut_scheduler_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] x_in;
  logic [NUM_REQ-1:0]        ack;
  data_t                     res_data;
  logic                      busy;
  logic [ADDR_W-1:0]         lut_addr;
  data_t                     lut_base;
  data_t                     lut_next;

  modport slave (
    input  req, x_in, lut_base, lut_next,
    output ack, res_data, busy, lut_addr
  );

  modport master (
    output req, x_in, lut_base, lut_next,
    input  ack, res_data, busy, lut_addr
  );

endinterface

// File: rtl/act_lut_scheduler_lut_interp.sv
// Linear interpolation between two adjacent LUT entries, weighted by the unsigned
// fractional part of the input, saturated to the signed data range.
module lut_interp
  import act_lut_scheduler_pkg::*;
(
  input  data_t             base_i,
  input  data_t             next_i,
  input  logic [FRAC_W-1:0] frac_i,
  output data_t             y_o
);

  localparam logic signed [DATA_W+1:0] MAX_Y = 10'sd127;
  localparam logic signed [DATA_W+1:0] MIN_Y = -10'sd128;

  logic signed [DATA_W:0]          diff;
  logic signed [DATA_W+FRAC_W+1:0] prod;
  logic signed [DATA_W+1:0]        sum;

  // The 10-bit sum holds b plus a shifted product of at most +/-239 without overflow.
  always_comb begin
    diff = {next_i[DATA_W-1], next_i} - {base_i[DATA_W-1], base_i};
    prod = 14'(diff) * 14'($signed({1'b0, frac_i}));
    sum  = 10'(base_i) + 10'(prod >>> FRAC_W);
    if (sum > MAX_Y) begin
      y_o = data_t'(MAX_Y[DATA_W-1:0]);
    end else if (sum < MIN_Y) begin
      y_o = data_t'(MIN_Y[DATA_W-1:0]);
    end else begin
      y_o = data_t'(sum[DATA_W-1:0]);
    end
  end

endmodule

// File: rtl/act_lut_scheduler.sv
// Round-robin scheduler sharing one activation LUT among NUM_REQ neuron units:
// grant, look up, interpolate, then pulse ack to the winner.
module act_lut_scheduler
  import act_lut_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  act_lut_scheduler_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e            state_q, state_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    lastGrant_q, lastGrant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  data_t             base_q, base_d;
  data_t             next_q, next_d;
  data_t             res_q, res_d;

  logic              pickValid;
  logic [IDW-1:0]    pick;
  logic [DATA_W-1:0] xSel;
  data_t             interpY;

  lut_interp u_interp (
    .base_i (base_q),
    .next_i (next_q),
    .frac_i (frac_q),
    .y_o    (interpY)
  );

  // Scan starts one past the last served requester so everyone gets a turn.
  always_comb begin
    pickValid = 1'b0;
    pick      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pickValid && bus.req[(int'(lastGrant_q) + k) % NUM_REQ]) begin
        pickValid = 1'b1;
        pick      = IDW'((int'(lastGrant_q) + k) % NUM_REQ);
      end
    end
    xSel = bus.x_in[int'(pick)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    frac_d      = frac_q;
    base_d      = base_q;
    next_d      = next_q;
    res_d       = res_q;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          id_d    = pick;
          addr_d  = xSel[DATA_W-1:FRAC_W];
          frac_d  = xSel[FRAC_W-1:0];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        base_d  = bus.lut_base;
        next_d  = bus.lut_next;
        state_d = CALC;
      end
      CALC: begin
        res_d   = interpY;
        state_d = ACK;
      end
      ACK: begin
        lastGrant_d = id_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      lastGrant_q <= IDW'(NUM_REQ - 1);
      addr_q      <= '0;
      frac_q      <= '0;
      base_q      <= '0;
      next_q      <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      frac_q      <= frac_d;
      base_q      <= base_d;
      next_q      <= next_d;
      res_q       <= res_d;
    end
  end

  always_comb begin
    bus.ack = '0;
    if (state_q == ACK) begin
      bus.ack[id_q] = 1'b1;
    end
    bus.busy     = (state_q != IDLE);
    bus.lut_addr = addr_q;
    bus.res_data = res_q;
  end

endmodule

// File: tb/tb_act_lut_scheduler.sv
// Self-checking bench for act_lut_scheduler: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed results.
module tb_act_lut_scheduler;
  import act_lut_scheduler_pkg::*;

  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;
  int   cycleCount  = 0;
  bit   started     = 1'b0;

  act_lut_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  act_lut_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // LUT contents 0,12,15 x6,-15 x7,-12; address 15 wraps to 0, address 7 pairs with itself.
  int lutTable [16] = '{0, 12, 15, 15, 15, 15, 15, 15,
                        -15, -15, -15, -15, -15, -15, -15, -12};

  function automatic int lutNextIdx(input int a);
    return (a == 7) ? 7 : (a + 1) % 16;
  endfunction

  always_comb begin
    bus.lut_base = data_t'(lutTable[int'(bus.lut_addr)]);
    bus.lut_next = data_t'(lutTable[lutNextIdx(int'(bus.lut_addr))]);
  end

  function automatic int expectedY(input logic [7:0] x);
    int a, f, b, n, y;
    a = int'(x[7:4]);
    f = int'(x[3:0]);
    b = lutTable[a];
    n = lutTable[lutNextIdx(a)];
    y = b + (((n - b) * f) >>> 4);
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  // A service occupies the grant cycle plus three more; the result shows with ack.
  int          mCnt    = 0;
  int          mWinner = 0;
  int          mLast   = NUM_REQ - 1;
  int          mRes    = 0;
  int          mAddr   = 0;
  logic [7:0]  mX      = '0;

  always @(posedge clk) begin
    started = 1'b1;
    cycleCount++;
    if (!rst) begin
      mCnt  = 0;
      mLast = NUM_REQ - 1;
      mRes  = 0;
      mAddr = 0;
    end else if (mCnt > 0) begin
      mCnt--;
      if (mCnt == 1) mRes = expectedY(mX);
      if (mCnt == 0) mLast = mWinner;
    end else if (|bus.req) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (mCnt == 0 && bus.req[(mLast + k) % NUM_REQ]) begin
          mWinner = (mLast + k) % NUM_REQ;
          mX      = bus.x_in[mWinner*DATA_W +: DATA_W];
          mAddr   = int'(mX[7:4]);
          mCnt    = 3;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, actual, expected, cycleCount);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model.ack", bus.ack, (mCnt == 1) ? (1 << mWinner) : 0);
      checkOutput("model.busy", bus.busy, (mCnt > 0) ? 1 : 0);
      checkOutput("model.res_data", bus.res_data, mRes);
      checkOutput("model.lut_addr", bus.lut_addr, mAddr);
    end
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*DATA_W-1:0] x);
    bus.req  = r;
    bus.x_in = x;
  endtask

  task automatic waitAck(input string name, input logic [NUM_REQ-1:0] expAck,
                         input int expRes, output int latency);
    latency = 0;
    do begin
      @(negedge clk);
      latency++;
    end while (bus.ack == '0 && latency < 20);
    if (bus.ack == '0) begin
      checkOutput({name, ".timeout"}, bus.ack, expAck);
    end else begin
      checkOutput({name, ".ack"}, bus.ack, expAck);
      checkOutput({name, ".res"}, bus.res_data, expRes);
    end
  endtask

  task automatic serveOne(input string name, input logic [7:0] x, input int expAddr, input int expRes);
    int lat;
    applyStimulus(4'b0001, {24'h0, x});
    waitAck(name, 4'b0001, expRes, lat);
    checkOutput({name, ".addr"}, bus.lut_addr, expAddr);
    applyStimulus(4'b0000, {24'h0, x});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int lastCycle;
    rst = 1'b0;
    applyStimulus(4'b0001, {24'h0, 8'h18});
    repeat (3) @(negedge clk);
    checkOutput("reset.ack", bus.ack, 0);
    checkOutput("reset.busy", bus.busy, 0);
    checkOutput("reset.res", bus.res_data, 0);
    checkOutput("reset.addr", bus.lut_addr, 0);

    rst = 1'b1;
    waitAck("release", 4'b0001, 13, lat);
    checkOutput("release.latency", lat, 3);
    checkOutput("release.addr", bus.lut_addr, 1);
    applyStimulus(4'b0000, {24'h0, 8'h18});
    @(negedge clk);

    serveOne("x0F", 8'h0F, 0, 11);
    serveOne("xF8wrap", 8'hF8, 15, -6);
    serveOne("x80", 8'h80, 8, -15);
    serveOne("x78flat", 8'h78, 7, 15);

    // Requester drops its request one cycle after the grant.
    applyStimulus(4'b0001, {24'h0, 8'h18});
    @(negedge clk);
    applyStimulus(4'b0000, {24'h0, 8'h18});
    waitAck("drop", 4'b0001, 13, lat);
    checkOutput("drop.latency", lat, 2);
    repeat (6) @(negedge clk);
    checkOutput("drop.noRegrant", bus.busy, 0);

    // Requester 1 is next in rotation, but a reset in CALC restores requester 0 priority.
    applyStimulus(4'b0011, {16'h0, 8'h0F, 8'h18});
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort.inCalcBusy", bus.busy, 1);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort.ack", bus.ack, 0);
      checkOutput("abort.res", bus.res_data, 0);
    end
    rst = 1'b1;
    waitAck("abort.first", 4'b0001, 13, lat);
    applyStimulus(4'b0010, {16'h0, 8'h0F, 8'h18});
    waitAck("abort.second", 4'b0010, 11, lat);
    applyStimulus(4'b0000, {16'h0, 8'h0F, 8'h18});

    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'b1111, {4{8'h10}});
    lastCycle = 0;
    for (int k = 0; k < 5; k++) begin
      waitAck($sformatf("rr%0d", k), 4'(1 << (k % NUM_REQ)), 12, lat);
      if (k > 0) checkOutput($sformatf("rr%0d.spacing", k), cycleCount - lastCycle, 4);
      lastCycle = cycleCount;
    end
    applyStimulus(4'b0000, {4{8'h10}});
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
